cipher_uart_tx: RTL

CIPHER_UART_TX -- requirements
Module: cipher_uart_tx

---
 rtl/cipher_pkg.sv | 22 ++
 rtl/cipher_fifo.sv | 82 ++++++++
 rtl/cipher_uart_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cipher_pkg.sv
// -----------------------------------------------------------------------------
// cipher_pkg
// Shared types and constants for the cipher serial transmit path.
//   ASCII_W          : width of one character
//   tx_state_t       : serial framer states
//   CLKS_PER_BIT_DEF : default clocks per serial bit
//   FIFO_DEPTH_DEF   : default character buffer depth
// -----------------------------------------------------------------------------
package cipher_pkg;

   localparam int ASCII_W          = 8;
   localparam int CLKS_PER_BIT_DEF = 16;
   localparam int FIFO_DEPTH_DEF   = 4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/cipher_fifo.sv
// -----------------------------------------------------------------------------
// cipher_fifo
// Synchronous first-word-fall-through character buffer. The head entry is
// always visible on rdata while the buffer is non-empty.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   push/wdata : write wdata when push=1 and not full
//   pop        : drop the head entry when pop=1 and not empty
//   rdata      : head entry
//   count      : number of stored entries (0..DEPTH)
//   full/empty : count==DEPTH / count==0
// -----------------------------------------------------------------------------
module cipher_fifo
   import cipher_pkg::*;
#(
   parameter  int DEPTH = FIFO_DEPTH_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [ASCII_W-1:0] wdata,
   input  logic               pop,
   output logic [ASCII_W-1:0] rdata,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty
);

   logic [ASCII_W-1:0] mem_q [DEPTH];
   logic [ASCII_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_push;
   logic               do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointers are exactly log2(DEPTH) wide, so the increment wraps modulo
   // DEPTH without an explicit compare.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cipher_uart_tx.sv
// -----------------------------------------------------------------------------
// cipher_uart_tx
// Buffers ciphered ASCII characters and sends each as an 8N1 serial frame
// (start bit, 8 data bits LSB first, stop bit), CLKS_PER_BIT clocks per bit.
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   in_valid    : in_data carries a character
//   in_data     : character to send
//   in_ready    : buffer can take a character this cycle
//   tx          : registered serial line, idle high
//   busy        : frame on the line or characters buffered
//   fifo_count  : number of buffered characters
// -----------------------------------------------------------------------------
module cipher_uart_tx
   import cipher_pkg::*;
#(
   parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter  int FIFO_DEPTH   = FIFO_DEPTH_DEF,
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [ASCII_W-1:0] in_data,
   output logic               in_ready,
   output logic               tx,
   output logic               busy,
   output logic [CNT_W-1:0]   fifo_count
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam int                BIT_W     = $clog2(ASCII_W);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(ASCII_W - 1);

   tx_state_t          state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d;
   logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
   logic [ASCII_W-1:0] shift_q, shift_d;
   logic               tx_q, tx_d;

   logic               fifo_push;
   logic               fifo_pop;
   logic [ASCII_W-1:0] fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic               baud_wrap;

   // full is count==DEPTH, so !full is exactly count < DEPTH.
   assign in_ready  = ~fifo_full;
   assign fifo_push = in_valid & in_ready;
   assign baud_wrap = (baud_q == BAUD_LAST);
   assign busy      = (state_q != IDLE) | ~fifo_empty;
   assign tx        = tx_q;

   cipher_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (in_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // tx_d is the line value for the next cycle, so every transition is
   // decided one cycle ahead and tx comes straight from a flop.
   // shift_q[0] is always the bit currently on the line during DATA.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      fifo_pop  = 1'b0;
      baud_d    = (state_q == IDLE || baud_wrap) ? '0 : baud_q + BAUD_W'(1);

      case (state_q)
         IDLE: begin
            tx_d      = 1'b1;
            bit_idx_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               state_d  = START;
               tx_d     = 1'b0;
            end
         end
         START: begin
            if (baud_wrap) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (baud_wrap) begin
               if (bit_idx_q == BIT_LAST) begin
                  state_d   = STOP;
                  bit_idx_d = '0;
                  tx_d      = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
                  shift_d   = {1'b0, shift_q[ASCII_W-1:1]};
                  tx_d      = shift_q[1];
               end
            end
         end
         STOP: begin
            // Chain straight into the next frame when a character waits,
            // so back-to-back characters leave no idle gap on the line.
            if (baud_wrap) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  state_d  = START;
                  tx_d     = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // Reset forces tx high asynchronously, aborting any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
      end
   end

endmodule
